// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered pop output, a combinational head peek and error flags.
// Define SYNC_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until rst.
module sync_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [W-1:0]               peek_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  pop_data_q, pop_data_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign pop_data  = pop_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign peek_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok      = pop && !empty;
    push_ok     = push && (!full || pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_data_d  = pop_data_q;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    overflow_d  = overflow_q  | (push && !push_ok);
    underflow_d = underflow_q | (pop && !pop_ok);
`else
    overflow_d  = push && !push_ok;
    underflow_d = pop && !pop_ok;
`endif
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      pop_data_d = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only occupied entries are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (W=72, DEPTH=4): directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_sync_fifo;
  localparam int W = 72;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop;
  logic [W-1:0]  push_data;
  logic [W-1:0]  pop_data, peek_data;
  logic          empty, full, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_pop;
  logic         m_ovf, m_unf;

  sync_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .peek_data(peek_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] m_peek();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pop = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one edge of stimulus and advances the reference model.
  task automatic drive(input logic ps, input logic [W-1:0] d, input logic pp);
    bit pop_ok, push_ok, ovf_now, unf_now;
    push = ps; push_data = d; pop = pp;
    pop_ok  = pp && (mq.size() > 0);
    push_ok = ps && ((mq.size() < DEPTH) || pop_ok);
    ovf_now = ps && !push_ok;
    unf_now = pp && !pop_ok;
    @(posedge clk);
    #1;
    if (pop_ok) m_pop = mq.pop_front();
    if (push_ok) mq.push_back(d);
`ifdef SYNC_FIFO_STICKY_ERR_EN
    m_ovf = m_ovf | ovf_now;
    m_unf = m_unf | unf_now;
`else
    m_ovf = ovf_now;
    m_unf = unf_now;
`endif
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (pop_data !== '0) begin errors++; $display("FAIL reset_pop_data: got %h expected 0", pop_data); end
    checks++; if (peek_data !== '0) begin errors++; $display("FAIL reset_peek: got %h expected 0", peek_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", overflow, underflow); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, W'(i), 1'b0);
      checks++; if (peek_data !== W'(1)) begin errors++; $display("FAIL fill_peek[%0d]: got %h expected 1", i, peek_data); end
      checks++; if (count !== CW'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
      checks++; if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, i == DEPTH); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow[%0d]: got %b expected 0", i, overflow); end
      $display("fill push %0d count=%0d peek=%h", i, count, peek_data);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, W'(5), 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", count, DEPTH); end
    drive(1'b0, '0, 1'b0);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_after: got %b expected %b", overflow, m_ovf); end
    $display("overflow push 0x5 count=%0d", count);
  endtask

  task automatic test_drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1);
      checks++; if (pop_data !== m_pop) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, pop_data, m_pop); end
      checks++; if (peek_data !== m_peek()) begin errors++; $display("FAIL drain_peek[%0d]: got %h expected %h", i, peek_data, m_peek()); end
      checks++; if (underflow !== m_unf) begin errors++; $display("FAIL drain_underflow[%0d]: got %b expected %b", i, underflow, m_unf); end
      $display("drain pop %0d data=%h peek=%h", i, pop_data, peek_data);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_underflow();
    logic [W-1:0] held;
    held = m_pop;
    drive(1'b0, '0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b expected 1", underflow); end
    checks++; if (pop_data !== held) begin errors++; $display("FAIL unf_pop_data: got %h expected %h", pop_data, held); end
    checks++; if (count !== '0) begin errors++; $display("FAIL unf_count: got %0d expected 0", count); end
    drive(1'b0, '0, 1'b0);
    checks++; if (underflow !== m_unf) begin errors++; $display("FAIL unf_after: got %b expected %b", underflow, m_unf); end
    $display("underflow pop_data=%h", pop_data);
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, W'(i), 1'b0);
    drive(1'b1, W'('hA), 1'b1);
    checks++; if (pop_data !== W'(1)) begin errors++; $display("FAIL sim_full_pop: got %h expected 1", pop_data); end
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL sim_full_count: got %0d expected %0d", count, DEPTH); end
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL sim_full_ovf: got %b expected %b", overflow, m_ovf); end
    $display("simultaneous full pop_data=%h count=%0d", pop_data, count);
    test_drain(DEPTH);
    checks++; if (pop_data !== W'('hA)) begin errors++; $display("FAIL sim_wrap_last: got %h expected a", pop_data); end
    drive(1'b1, W'('h77), 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_unf: got %b expected 1", underflow); end
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL sim_empty_count: got %0d expected 1", count); end
    checks++; if (peek_data !== W'('h77)) begin errors++; $display("FAIL sim_empty_peek: got %h expected 77", peek_data); end
    checks++; if (pop_data !== W'('hA)) begin errors++; $display("FAIL sim_empty_nobypass: got %h expected a", pop_data); end
    $display("simultaneous empty count=%0d peek=%h", count, peek_data);
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {8'($urandom), $urandom, $urandom};
      drive($urandom_range(0, 99) < 55, d, $urandom_range(0, 99) < 45);
      checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, mq.size()); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d]: got %b", i, empty); end
      checks++; if (full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d]: got %b", i, full); end
      checks++; if (peek_data !== m_peek()) begin errors++; $display("FAIL rnd_peek[%0d]: got %h expected %h", i, peek_data, m_peek()); end
      checks++; if (pop_data !== m_pop) begin errors++; $display("FAIL rnd_pop_data[%0d]: got %h expected %h", i, pop_data, m_pop); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", i, overflow, m_ovf); end
      checks++; if (underflow !== m_unf) begin errors++; $display("FAIL rnd_underflow[%0d]: got %b expected %b", i, underflow, m_unf); end
      $display("rnd %0d push=%b pop=%b count=%0d pop_data=%h", i, push, pop, count, pop_data);
      if (i == n / 2) begin
        // Reset between edges must clear state without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++; if ({empty, count} !== {1'b1, CW'(0)}) begin errors++; $display("FAIL rnd_async_rst: got empty=%b count=%0d", empty, count); end
        checks++; if (pop_data !== '0) begin errors++; $display("FAIL rnd_async_rst_pop: got %h expected 0", pop_data); end
        rst = 1'b0;
        $display("rnd async reset applied");
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain(DEPTH);
    test_underflow();
    test_reset();
    test_simultaneous();
    test_reset();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
